// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default geometry, starvation
// limit and the arbiter FSM state encoding.
package vram_pkg;

   localparam int ADDR_W_DEF     = 16;
   localparam int DATA_W_DEF     = 8;
   localparam int STARVE_MAX_DEF = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      VID_ADDR = 3'd1,
      VID_DATA = 3'd2,
      CPU_ADDR = 3'd3,
      CPU_DATA = 3'd4
   } state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the video fetcher, the CPU, the arbiter and the
// single-port synchronous VRAM. The slave modport is the arbiter's view;
// the master modport is the view of everything around it.
interface vram_arbiter_if
   import vram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_ack;
   logic [DATA_W-1:0] vid_data;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output vid_ack, vid_data, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  vid_ack, vid_data, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/vram_arbiter.sv
// Two-requester arbiter for a single-port synchronous VRAM. Video scanout
// normally wins; after STARVE_MAX consecutive video grants with the CPU
// waiting, the CPU is granted once. Each access takes three cycles:
// grant (IDLE), address phase, data phase with a one-cycle ack.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic           clock_25,
   input  logic           reset,
   vram_arbiter_if.slave  bus
);

   localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_starve_cnt;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_we;
   logic [DATA_W-1:0]  r_wdata;
   logic               r_vid_ack;
   logic               r_cpu_ack;

   logic               w_cpu_starved;
   logic               w_grant_vid;
   logic               w_grant_cpu;
   logic               w_vid_ack;
   logic               w_cpu_ack;

   assign w_cpu_starved = bus.cpu_req && (r_starve_cnt == CNT_MAX);
   assign w_grant_vid   = bus.vid_req && !w_cpu_starved;
   assign w_grant_cpu   = bus.cpu_req && !w_grant_vid;

   // Reset takes effect combinationally on the strobes so that an access
   // interrupted by reset never writes or acks in the reset cycle itself.
   assign w_vid_ack      = r_vid_ack && !reset;
   assign w_cpu_ack      = r_cpu_ack && !reset;
   assign bus.vid_ack    = w_vid_ack;
   assign bus.cpu_ack    = w_cpu_ack;
   assign bus.mem_we     = (r_state == CPU_ADDR) && r_we && !reset;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wdata  = r_wdata;

   // The RAM output is already registered; it is routed straight through
   // during the ack cycle and forced to zero otherwise.
   assign bus.vid_data  = w_vid_ack ? bus.mem_rdata : {DATA_W{1'b0}};
   assign bus.cpu_rdata = w_cpu_ack ? bus.mem_rdata : {DATA_W{1'b0}};

   // Arbitration FSM, latched request, starvation counter and ack pulses.
   always_ff @(posedge clock_25) begin
      if (reset) begin
         r_state      <= IDLE;
         r_starve_cnt <= {CNT_W{1'b0}};
         r_addr       <= {ADDR_W{1'b0}};
         r_we         <= 1'b0;
         r_wdata      <= {DATA_W{1'b0}};
         r_vid_ack    <= 1'b0;
         r_cpu_ack    <= 1'b0;
      end else begin
         r_vid_ack <= 1'b0;
         r_cpu_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_vid) begin
                  r_addr  <= bus.vid_addr;
                  r_state <= VID_ADDR;
                  if (bus.cpu_req) begin
                     r_starve_cnt <= (r_starve_cnt == CNT_MAX) ? CNT_MAX
                                                               : r_starve_cnt + CNT_ONE;
                  end else begin
                     r_starve_cnt <= {CNT_W{1'b0}};
                  end
               end else if (w_grant_cpu) begin
                  r_addr       <= bus.cpu_addr;
                  r_we         <= bus.cpu_we;
                  r_wdata      <= bus.cpu_wdata;
                  r_starve_cnt <= {CNT_W{1'b0}};
                  r_state      <= CPU_ADDR;
               end else begin
                  // No grant here implies cpu_req is low.
                  r_starve_cnt <= {CNT_W{1'b0}};
                  r_state      <= IDLE;
               end
            end
            VID_ADDR: begin
               r_vid_ack <= 1'b1;
               r_state   <= VID_DATA;
            end
            VID_DATA: begin
               r_state <= IDLE;
            end
            CPU_ADDR: begin
               r_cpu_ack <= 1'b1;
               r_state   <= CPU_DATA;
            end
            CPU_DATA: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM.
module tb_vram_arbiter;
   import vram_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   int   cyc;
   int   last_ack_cyc;
   logic [7:0] ram [0:65535];

   vram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   vram_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(8)) dut (
      .clock_25 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Cycle counter used to measure ack spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port RAM: write-first not needed, read returns old data.
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      else
         n_pass++;
   endtask

   // Ack pulses and the write strobe must be mutually exclusive.
   always @(negedge clk) begin
      if (!rst)
         chk("excl", 32'($countones({bus.vid_ack, bus.cpu_ack, bus.mem_we}) > 1), 32'd0);
   end

   task automatic vid_access(input string tag, input logic [15:0] addr, input logic [7:0] exp);
      int  k;
      int  we_cnt;
      bit  got;
      logic [7:0] data;
      bus.vid_req  = 1'b1;
      bus.vid_addr = addr;
      k = 0; we_cnt = 0; got = 1'b0; data = 8'h00;
      while (!got && k < 10) begin
         @(negedge clk);
         if (bus.mem_we) we_cnt++;
         if (bus.vid_ack) begin
            got  = 1'b1;
            data = bus.vid_data;
         end else begin
            k++;
         end
      end
      chk({tag, " lat"}, k, 2);
      chk({tag, " data"}, data, exp);
      chk({tag, " we"}, we_cnt, 0);
      last_ack_cyc = cyc;
      @(posedge clk); #1;
      bus.vid_req = 1'b0;
   endtask

   task automatic cpu_access(input string tag, input logic we, input logic [15:0] addr,
                             input logic [7:0] wdata, input logic [7:0] exp);
      int  k;
      int  we_cnt;
      int  we_k;
      bit  got;
      logic [7:0] data;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      k = 0; we_cnt = 0; we_k = -1; got = 1'b0; data = 8'h00;
      while (!got && k < 10) begin
         @(negedge clk);
         if (bus.mem_we) begin
            we_cnt++;
            we_k = k;
         end
         if (bus.cpu_ack) begin
            got  = 1'b1;
            data = bus.cpu_rdata;
         end else begin
            k++;
         end
      end
      chk({tag, " lat"}, k, 2);
      if (we) begin
         chk({tag, " we_cnt"}, we_cnt, 1);
         chk({tag, " we_cyc"}, we_k, 1);
      end else begin
         chk({tag, " we_cnt"}, we_cnt, 0);
         chk({tag, " rdata"}, data, exp);
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
   endtask

   initial begin
      int  n;
      int  k;
      int  vid_k;
      int  cpu_k;
      int  seq [18];
      int  prev;

      n_checks = 0; n_pass = 0; cyc = 0; last_ack_cyc = 0;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      ram[16'h0100] = 8'hA5;
      for (int i = 0; i < 8; i++) ram[i] = 8'h10 + 8'(i);
      rst = 1'b1;
      bus.vid_req = 1'b0; bus.vid_addr = 16'h0000;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst vid_ack", bus.vid_ack, 0);
      chk("rst cpu_ack", bus.cpu_ack, 0);
      chk("rst mem_we", bus.mem_we, 0);
      chk("rst mem_addr", bus.mem_addr, 0);
      chk("rst vid_data", bus.vid_data, 0);
      chk("rst cpu_rdata", bus.cpu_rdata, 0);
      chk("rst state", 32'(dut.r_state), 32'(IDLE));
      @(posedge clk); #1;

      // Video read only
      vid_access("vid1", 16'h0100, 8'hA5);
      @(negedge clk);
      chk("idle hold addr", bus.mem_addr, 32'h0100);
      @(posedge clk); #1;

      // CPU write then read back
      cpu_access("cpuwr", 1'b1, 16'h1234, 8'h3C, 8'h00);
      chk("ram wr", ram[16'h1234], 8'h3C);
      cpu_access("cpurd", 1'b0, 16'h1234, 8'h00, 8'h3C);

      // Simultaneous first requests: video first, CPU 3 cycles later
      bus.vid_req = 1'b1; bus.vid_addr = 16'h0100;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
      vid_k = -1; cpu_k = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.vid_ack) begin
            vid_k = i;
            chk("sim vdata", bus.vid_data, 8'hA5);
         end
         if (bus.cpu_ack) begin
            cpu_k = i;
            chk("sim cdata", bus.cpu_rdata, 8'h3C);
         end
         @(posedge clk); #1;
         if (vid_k == i) bus.vid_req = 1'b0;
         if (cpu_k == i) bus.cpu_req = 1'b0;
      end
      chk("sim vid_cyc", vid_k, 2);
      chk("sim cpu_cyc", cpu_k, 5);

      // Starvation: both held high, 8 video acks then one CPU ack, twice
      bus.vid_req = 1'b1; bus.vid_addr = 16'h0100;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
      n = 0; k = 0;
      while (n < 18 && k < 100) begin
         @(negedge clk);
         if (bus.vid_ack) begin seq[n] = 0; n++; end
         else if (bus.cpu_ack) begin seq[n] = 1; n++; end
         k++;
         if (n < 18) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
      chk("starve n", n, 18);
      for (int i = 0; i < 18; i++)
         chk($sformatf("starve seq%0d", i), seq[i], (i % 9 == 8) ? 1 : 0);

      // Reset during CPU_ADDR of a write
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2000; bus.cpu_wdata = 8'h55;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid state_pre", 32'(dut.r_state), 32'(CPU_ADDR));
      chk("rstmid mem_we", bus.mem_we, 0);
      chk("rstmid cpu_ack", bus.cpu_ack, 0);
      @(posedge clk); #1;
      rst = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
      @(negedge clk);
      chk("rstmid cpu_ack2", bus.cpu_ack, 0);
      chk("rstmid state", 32'(dut.r_state), 32'(IDLE));
      chk("rstmid cnt", 32'(dut.r_starve_cnt), 0);
      chk("rstmid ram", ram[16'h2000], 8'h00);
      @(posedge clk); #1;

      // Back-to-back video reads at 0..7
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         vid_access($sformatf("b2b%0d", i), 16'(i), 8'h10 + 8'(i));
         if (i > 0) chk($sformatf("b2b gap%0d", i), last_ack_cyc - prev, 3);
         prev = last_ack_cyc;
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: VRAM address width.
REQ-002 Parameter DATA_W, default 8: VRAM data width.
REQ-003 Parameter STARVE_MAX, default 8: consecutive video grants allowed while the CPU waits.
REQ-004 clock_25  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 vid_req  in  1  scanout fetch request; level, held until vid_ack.
REQ-007 vid_addr  in  ADDR_W  scanout fetch address.
REQ-008 vid_ack  out  1  one-cycle pulse; read data valid.
REQ-009 vid_data  out  DATA_W  fetched byte, valid while vid_ack=1.
REQ-010 cpu_req  in  1  CPU access request; level, held until cpu_ack.
REQ-011 cpu_we  in  1  1=write, 0=read.
REQ-012 cpu_addr  in  ADDR_W  CPU address.
REQ-013 cpu_wdata  in  DATA_W  CPU write data.
REQ-014 cpu_ack  out  1  one-cycle completion pulse.
REQ-015 cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1 on a read.
REQ-016 mem_addr  out  ADDR_W  single-port VRAM address.
REQ-017 mem_we  out  1  VRAM write strobe.
REQ-018 mem_wdata  out  DATA_W  VRAM write data.
REQ-019 mem_rdata  in  DATA_W  VRAM read data, synchronous RAM, valid 1 cycle after mem_addr.

Function
REQ-020 FSM states: IDLE, VID_ADDR, VID_DATA, CPU_ADDR, CPU_DATA.
REQ-021 IDLE arbitration: grant video if vid_req and not (cpu_req and starve_cnt==STARVE_MAX); else grant CPU if cpu_req; else stay in IDLE.
REQ-022 On grant, latch requester addr (plus cpu_we and cpu_wdata for CPU) and move to the *_ADDR state.
REQ-023 *_ADDR drives mem_addr from the latched address; next state is the matching *_DATA.
REQ-024 mem_we=1 only in CPU_ADDR with latched we=1, exactly one cycle; mem_wdata = latched wdata.
REQ-025 VID_DATA: vid_ack=1, vid_data=mem_rdata; next state IDLE.
REQ-026 CPU_DATA: cpu_ack=1, cpu_rdata=mem_rdata; writes also ack here; next state IDLE.
REQ-027 Latency: req sampled in IDLE at cycle N, ack at cycle N+2; throughput one access per 3 cycles.
REQ-028 A requester must drop req in the cycle after its ack; if req is still high in IDLE, it is a new request.
REQ-029 starve_cnt increments on each video grant made while cpu_req=1, saturating at STARVE_MAX.
REQ-030 starve_cnt clears on a CPU grant, or in any IDLE cycle with cpu_req=0.
REQ-031 Simultaneous vid_req and cpu_req with starve_cnt<STARVE_MAX: video wins.
REQ-032 Inputs are ignored outside IDLE; req changes mid-access do not affect the access in flight.
REQ-033 mem_addr holds its last value in IDLE; vid_ack, cpu_ack and mem_we are never high at the same time.

Reset
REQ-034 Reset forces state IDLE, starve_cnt=0, latched regs=0, mem_addr=0, mem_we=0, vid_ack=0, cpu_ack=0, vid_data=0, cpu_rdata=0.
REQ-035 Reset mid-access abandons the access with no ack; a pending mem_we is suppressed from the reset cycle on.

Structure
REQ-036 Shared package vram_pkg holds ADDR_W, DATA_W, STARVE_MAX defaults and the FSM state encoding.
REQ-037 Single module with no sub-module; the starvation counter is inline.

Verification
REQ-038 Video read only: RAM[0x0100]=0xA5, vid_req at cycle N -> vid_ack and vid_data=0xA5 at N+2; mem_we stays 0.
REQ-039 CPU write then read: write 0x3C to 0x1234 -> one mem_we pulse at N+1, cpu_ack at N+2; the following read returns cpu_rdata=0x3C.
REQ-040 Simultaneous first requests from both -> video granted first; CPU acked 3 cycles after vid_ack.
REQ-041 vid_req held high continuously with cpu_req high -> exactly 8 video acks, then a cpu_ack; the pattern repeats.
REQ-042 reset asserted in CPU_ADDR of a write -> no mem_we in the reset cycle, no cpu_ack, state IDLE and counter 0 afterwards.
REQ-043 Back-to-back video requests at addresses 0..7 -> acks every 3 cycles with data in address order.
